// File: rtl/step_stim_ctrl.sv
// Single-step emulation initiator: plays a stimulus table into the model one step at a time,
// pulses go once per step and captures v_out into a buffer the host reads back.
module step_stim_ctrl #(
   parameter int WIDTH  = 25,
   parameter int ADDR_W = 8,
   parameter int SETTLE = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stim_we,
   input  logic [ADDR_W-1:0] stim_addr,
   input  logic [WIDTH-1:0]  stim_data,
   input  logic [ADDR_W:0]   num_steps,
   input  logic              start,
   output logic [WIDTH-1:0]  v_in,
   output logic              go,
   output logic              model_rst,
   input  logic [WIDTH-1:0]  v_out,
   input  logic [ADDR_W-1:0] cap_addr,
   output logic [WIDTH-1:0]  cap_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   step_cnt
);

   // state     | meaning
   // S_IDLE    | after reset, waiting for start
   // S_LOAD    | stimulus read at k (lands in v_in on exit)
   // S_APPLY   | v_in held for SETTLE cycles
   // S_STEP    | go pulse to the single-step clock generator
   // S_WAIT    | model settles for SETTLE cycles
   // S_CAPTURE | v_out written to cap[k], step_cnt updated
   // S_DONE    | run complete, waiting for next start
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_APPLY, S_STEP, S_WAIT, S_CAPTURE, S_DONE
   } state_t;

   localparam int DEPTH = 1 << ADDR_W;
   localparam int TMR_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(DEPTH);
   localparam logic [TMR_W-1:0] TMR_LD  = TMR_W'(SETTLE - 1);

   state_t state, state_nx;

   logic [WIDTH-1:0]  stim_mem [DEPTH];
   logic [WIDTH-1:0]  cap_mem  [DEPTH];
   logic [ADDR_W-1:0] k;
   logic [ADDR_W:0]   n;
   logic [ADDR_W:0]   n_sat;
   logic [ADDR_W:0]   k_next;
   logic [TMR_W-1:0]  tmr;
   logic              idle_like;
   logic              start_acc;

   assign idle_like = (state == S_IDLE) || (state == S_DONE);
   assign start_acc = start && idle_like;
   assign n_sat     = (num_steps > DEPTH_V) ? DEPTH_V : num_steps;
   assign k_next    = {1'b0, k} + (ADDR_W+1)'(1);

   assign go        = (state == S_STEP);
   assign busy      = !idle_like;
   assign model_rst = idle_like;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nx = (num_steps == '0) ? S_DONE : S_LOAD;
         S_LOAD:         state_nx = S_APPLY;
         S_APPLY:        if (tmr == '0) state_nx = S_STEP;
         S_STEP:         state_nx = S_WAIT;
         S_WAIT:         if (tmr == '0) state_nx = S_CAPTURE;
         S_CAPTURE:      state_nx = (k_next == n) ? S_DONE : S_LOAD;
         default:        state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_in     <= '0;
         done     <= 1'b0;
         step_cnt <= '0;
         k        <= '0;
         n        <= '0;
         tmr      <= '0;
         cap_data <= '0;
      end else begin
         cap_data <= cap_mem[cap_addr];
         case (state)
            S_IDLE, S_DONE: begin
               if (start_acc) begin
                  n        <= n_sat;
                  k        <= '0;
                  step_cnt <= '0;
                  done     <= (num_steps == '0);
               end
            end
            S_LOAD: begin
               v_in <= stim_mem[k];
               tmr  <= TMR_LD;
            end
            S_APPLY, S_WAIT: if (tmr != '0) tmr <= tmr - 1'b1;
            S_STEP:          tmr <= TMR_LD;
            S_CAPTURE: begin
               step_cnt <= k_next;
               if (k_next == n) done <= 1'b1;
               else             k    <= k + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Table is frozen during a run; capture write is dropped if rst lands on CAPTURE.
   always_ff @(posedge clk) begin
      if (stim_we && idle_like) stim_mem[stim_addr] <= stim_data;
      if (!rst && state == S_CAPTURE) cap_mem[k] <= v_out;
   end

endmodule

// File: tb/tb_step_stim_ctrl.sv
// Directed bench for step_stim_ctrl with a one-go-delayed loopback model of the analog block.
module tb_step_stim_ctrl;
   localparam int WIDTH  = 25;
   localparam int ADDR_W = 8;
   localparam int SETTLE = 4;
   localparam int PERIOD = 2*SETTLE + 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              stim_we = 1'b0;
   logic [ADDR_W-1:0] stim_addr = '0;
   logic [WIDTH-1:0]  stim_data = '0;
   logic [ADDR_W:0]   num_steps = '0;
   logic              start = 1'b0;
   logic [WIDTH-1:0]  v_in;
   logic              go;
   logic              model_rst;
   logic [WIDTH-1:0]  v_out;
   logic [ADDR_W-1:0] cap_addr = '0;
   logic [WIDTH-1:0]  cap_data;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   step_cnt;

   logic [WIDTH-1:0]  lb_last;
   logic [WIDTH-1:0]  exp_stim [256];
   logic [WIDTH-1:0]  exp_cap  [4];

   int checks = 0;
   int failures = 0;

   step_stim_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .stim_we(stim_we), .stim_addr(stim_addr), .stim_data(stim_data),
      .num_steps(num_steps), .start(start), .v_in(v_in), .go(go), .model_rst(model_rst),
      .v_out(v_out), .cap_addr(cap_addr), .cap_data(cap_data), .busy(busy), .done(done),
      .step_cnt(step_cnt)
   );

   always #5 clk = ~clk;

   // Model output follows the input applied at the previous go.
   always @(posedge clk) begin
      if (rst) begin
         v_out   <= '0;
         lb_last <= '0;
      end else if (go) begin
         v_out   <= lb_last;
         lb_last <= v_in;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int a, input logic [WIDTH-1:0] d);
      stim_we   = 1'b1;
      stim_addr = a[ADDR_W-1:0];
      stim_data = d;
      tick();
      stim_we   = 1'b0;
      exp_stim[a] = d;
   endtask

   task automatic do_start(input int ns);
      num_steps = ns[ADDR_W:0];
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_wait(input int budget, input int inj, output int gos, output int first_go,
                           output int bad_gap, output int bad_vin, output int done_rises,
                           output bit timed_out);
      int   last_go;
      logic pd;
      gos = 0; first_go = -1; bad_gap = 0; bad_vin = 0; done_rises = 0;
      timed_out = 1'b1; last_go = -1; pd = done;
      for (int c = 0; c < budget; c++) begin
         if (c == inj) begin
            stim_we = 1'b1; stim_addr = 8'd3; stim_data = 25'h0ABCDE; start = 1'b1;
         end else begin
            stim_we = 1'b0; start = 1'b0;
         end
         tick();
         if (go === 1'b1) begin
            if (last_go < 0) first_go = c;
            else if (c - last_go != PERIOD) bad_gap++;
            if (gos < 256 && v_in !== exp_stim[gos]) bad_vin++;
            last_go = c;
            gos++;
         end
         if (done === 1'b1 && pd !== 1'b1) done_rises++;
         pd = done;
         if (done === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
      end
      stim_we = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      int gos, first_go, bad_gap, bad_vin, done_rises, cnt;
      bit timed_out;
      exp_cap[0] = 25'h0000000;
      exp_cap[1] = 25'h0000064;
      exp_cap[2] = 25'h1FFFF9C;
      exp_cap[3] = 25'h0FFFFFF;

      // reset values
      tick(); tick(); tick();
      chk("rst_v_in", v_in, 0);
      chk("rst_go", go, 0);
      chk("rst_model_rst", model_rst, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_step_cnt", step_cnt, 0);
      chk("rst_cap_data", cap_data, 0);
      rst = 1'b0;
      tick();

      // four-step run with loopback
      wr(0, 25'd100);
      wr(1, 25'h1FFFF9C);
      wr(2, 25'h0FFFFFF);
      wr(3, 25'h1000000);
      do_start(4);
      chk("run1_busy_after_start", busy, 1);
      chk("run1_model_rst_low", model_rst, 0);
      run_wait(200, -1, gos, first_go, bad_gap, bad_vin, done_rises, timed_out);
      chk("run1_timeout", timed_out, 0);
      chk("run1_go_count", gos, 4);
      chk("run1_first_go_latency", first_go, SETTLE);
      chk("run1_go_spacing_errs", bad_gap, 0);
      chk("run1_v_in_at_go_errs", bad_vin, 0);
      chk("run1_done", done, 1);
      chk("run1_step_cnt", step_cnt, 4);
      chk("run1_busy_end", busy, 0);
      chk("run1_model_rst_end", model_rst, 1);
      chk("run1_v_in_hold", v_in, 25'h1000000);
      for (int i = 0; i < 4; i++) begin
         cap_addr = i[ADDR_W-1:0];
         tick();
         chk($sformatf("cap_read_%0d", i), cap_data, exp_cap[i]);
      end

      // zero-step run from a clean reset
      rst = 1'b1; tick(); rst = 1'b0; tick();
      do_start(0);
      cnt = (go === 1'b1) ? 1 : 0;
      chk("zero_busy", busy, 0);
      tick();
      if (go === 1'b1) cnt++;
      chk("zero_done", done, 1);
      chk("zero_go_count", cnt, 0);
      chk("zero_step_cnt", step_cnt, 0);
      chk("zero_model_rst", model_rst, 1);

      // start and stim_we while busy are ignored
      do_start(4);
      chk("busy_inj_done_cleared", done, 0);
      run_wait(200, 6, gos, first_go, bad_gap, bad_vin, done_rises, timed_out);
      chk("inj_timeout", timed_out, 0);
      chk("inj_go_count", gos, 4);
      chk("inj_v_in_at_go_errs", bad_vin, 0);
      chk("inj_done_rises", done_rises, 1);
      chk("inj_step_cnt", step_cnt, 4);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (go === 1'b1) cnt++;
      end
      chk("inj_no_extra_go", cnt, 0);

      // rst in WAIT of the third step aborts the run
      do_start(4);
      cnt = 0;
      for (int i = 0; i < 100 && cnt < 3; i++) begin
         tick();
         if (go === 1'b1) cnt++;
      end
      chk("abort_reached_step", cnt, 3);
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("abort_go", go, 0);
      chk("abort_v_in", v_in, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_step_cnt", step_cnt, 0);
      chk("abort_model_rst", model_rst, 1);
      rst = 1'b0;
      tick();
      do_start(4);
      run_wait(200, -1, gos, first_go, bad_gap, bad_vin, done_rises, timed_out);
      chk("rerun_timeout", timed_out, 0);
      chk("rerun_go_count", gos, 4);
      chk("rerun_first_go_latency", first_go, SETTLE);
      chk("rerun_v_in_at_go_errs", bad_vin, 0);
      chk("rerun_step_cnt", step_cnt, 4);
      cap_addr = 8'd1;
      tick();
      chk("rerun_cap1", cap_data, 25'd100);

      // oversize num_steps saturates to the table depth
      for (int i = 0; i < 256; i++) wr(i, WIDTH'(i + 1000));
      do_start(300);
      run_wait(4000, -1, gos, first_go, bad_gap, bad_vin, done_rises, timed_out);
      chk("sat_timeout", timed_out, 0);
      chk("sat_go_count", gos, 256);
      chk("sat_go_spacing_errs", bad_gap, 0);
      chk("sat_v_in_at_go_errs", bad_vin, 0);
      chk("sat_step_cnt", step_cnt, 256);
      cap_addr = 8'd255;
      tick();
      chk("sat_cap255", cap_data, 25'd1254);
      cap_addr = 8'd254;
      tick();
      chk("sat_cap254", cap_data, 25'd1253);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
